// File: rtl/led_pkg.sv
// Shared constants and per-channel fade state encoding for the LED PWM fader.
package led_pkg;

  localparam int         NUM_CH  = 20;
  localparam logic [7:0] PWM_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_FULL = 2'd2,
    ST_FALL = 2'd3
  } fade_state_e;

endpackage

// File: rtl/led_fade_ch.sv
// One fader channel: ramp state, brightness level, PWM compare and output flop.
module led_fade_ch
  import led_pkg::*;
#(
  parameter int FADE_UP = 8,
  parameter int FADE_DN = 8,
  parameter bit OUT_INV = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fade_en_i,
  input  logic       tick_i,
  input  logic       tgt_i,
  input  logic [7:0] cnt_i,
  output logic       out_o
);

  localparam logic [8:0] UP9 = 9'(FADE_UP);
  localparam logic [8:0] DN9 = 9'(FADE_DN);

  fade_state_e state_q, state_d;
  logic [7:0]  lvl_q, lvl_d;
  logic        out_q, out_d;

  function automatic logic [7:0] sat_up(input logic [7:0] l);
    logic [8:0] s;
    s = {1'b0, l} + UP9;
    return s[8] ? PWM_MAX : s[7:0];
  endfunction

  // A borrow out of the 9-bit difference means the ramp went below zero.
  function automatic logic [7:0] sat_dn(input logic [7:0] l);
    logic [8:0] d;
    d = {1'b0, l} - DN9;
    return d[8] ? 8'd0 : d[7:0];
  endfunction

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    if (!fade_en_i) begin
      lvl_d   = tgt_i ? PWM_MAX : 8'd0;
      state_d = tgt_i ? ST_FULL : ST_OFF;
    end else begin
      if (tick_i) lvl_d = tgt_i ? sat_up(lvl_q) : sat_dn(lvl_q);
      unique case (state_q)
        ST_OFF:  if (tgt_i) state_d = (lvl_d == PWM_MAX) ? ST_FULL : ST_RISE;
        ST_RISE: begin
          if (!tgt_i)                  state_d = (lvl_d == 8'd0) ? ST_OFF : ST_FALL;
          else if (lvl_d == PWM_MAX)   state_d = ST_FULL;
        end
        ST_FULL: if (!tgt_i) state_d = (lvl_d == 8'd0) ? ST_OFF : ST_FALL;
        ST_FALL: begin
          if (tgt_i)                   state_d = (lvl_d == PWM_MAX) ? ST_FULL : ST_RISE;
          else if (lvl_d == 8'd0)      state_d = ST_OFF;
        end
      endcase
    end
  end

  // cnt never reaches 255, so a full level keeps the LED on for the whole period.
  assign out_d = (cnt_i < lvl_q) ^ OUT_INV;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      lvl_q   <= 8'd0;
      out_q   <= OUT_INV;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      out_q   <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/led_pwm_fader.sv
// PWM brightness fader between water_led and the board LEDs: input register,
// shared PWM counter and fade timebase, and 20 fader channels.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int FADE_DIV = 50000,
  parameter int FADE_UP  = 8,
  parameter int FADE_DN  = 8,
  parameter bit OUT_INV  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fade_en,
  input  logic [7:0] led_in,
  input  logic [2:0] ld1_in,
  input  logic [2:0] ld2_in,
  input  logic [2:0] ld3_in,
  input  logic [2:0] ld4_in,
  output logic [7:0] led,
  output logic [2:0] ld1,
  output logic [2:0] ld2,
  output logic [2:0] ld3,
  output logic [2:0] ld4
);

  localparam logic [20:0] TB_LAST = 21'(FADE_DIV - 1);

  logic [NUM_CH-1:0] tgt_q, tgt_d;
  logic              fade_en_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [20:0]       tb_q, tb_d;
  logic              tick;
  logic [NUM_CH-1:0] out_w;

  assign tgt_d = {ld4_in, ld3_in, ld2_in, ld1_in, led_in};
  assign tick  = (tb_q == TB_LAST);
  assign tb_d  = tick ? 21'd0 : tb_q + 21'd1;
  assign cnt_d = (cnt_q == PWM_MAX - 8'd1) ? 8'd0 : cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt_q     <= '0;
      fade_en_q <= 1'b0;
      cnt_q     <= 8'd0;
      tb_q      <= 21'd0;
    end else begin
      tgt_q     <= tgt_d;
      fade_en_q <= fade_en;
      cnt_q     <= cnt_d;
      tb_q      <= tb_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_fade_ch #(
      .FADE_UP (FADE_UP),
      .FADE_DN (FADE_DN),
      .OUT_INV (OUT_INV)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .fade_en_i (fade_en_q),
      .tick_i    (tick),
      .tgt_i     (tgt_q[g]),
      .cnt_i     (cnt_q),
      .out_o     (out_w[g])
    );
  end

  assign led = out_w[7:0];
  assign ld1 = out_w[10:8];
  assign ld2 = out_w[13:11];
  assign ld3 = out_w[16:14];
  assign ld4 = out_w[19:17];

endmodule
